// File: rtl/axis_event_pkg.sv
// Shared widths, beat-index encoding and counter sizing for the event packetizer.
package axis_event_pkg;

   localparam int EVENT_WIDTH     = 96;
   localparam int BEAT_WIDTH      = 32;
   localparam int BEATS_PER_EVENT = 3;

   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2
   } beat_idx_e;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2(input int unsigned value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if (((value - 1) >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_event_serializer.sv
// Output shifter O: one 96-bit event presented as three 32-bit beats, low word first.
// Beat 0 is valid the cycle after load; data and tlast hold while the sink stalls.
module axis_event_serializer
   import axis_event_pkg::*;
(
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   i_load,
   input  logic [EVENT_WIDTH-1:0] i_data,
   input  logic                   i_last,
   output logic                   o_free,
   output logic                   o_tvalid,
   input  logic                   i_tready,
   output logic [BEAT_WIDTH-1:0]  o_tdata,
   output logic                   o_tlast
);

   logic [EVENT_WIDTH-1:0] r_data;
   logic                   r_last;
   logic                   r_vld;
   logic                   w_vld_nxt;
   beat_idx_e              r_idx;
   beat_idx_e              w_idx_nxt;
   logic                   w_beat_hs;

   assign w_beat_hs = r_vld && i_tready;
   // Free either when empty or when the final beat leaves this cycle.
   assign o_free    = !r_vld || (w_beat_hs && (r_idx == BEAT2));

   always_comb begin
      w_idx_nxt = r_idx;
      w_vld_nxt = r_vld;
      if (i_load) begin
         w_idx_nxt = BEAT0;
         w_vld_nxt = 1'b1;
      end else if (w_beat_hs) begin
         case (r_idx)
            BEAT0:   w_idx_nxt = BEAT1;
            BEAT1:   w_idx_nxt = BEAT2;
            default: begin
               w_idx_nxt = BEAT0;
               w_vld_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_idx  <= BEAT0;
         r_vld  <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
      end else begin
         r_idx <= w_idx_nxt;
         r_vld <= w_vld_nxt;
         if (i_load) begin
            r_data <= i_data;
            r_last <= i_last;
         end
      end
   end

   always_comb begin
      o_tdata = '0;
      if (r_vld) begin
         case (r_idx)
            BEAT0:   o_tdata = r_data[BEAT_WIDTH-1:0];
            BEAT1:   o_tdata = r_data[2*BEAT_WIDTH-1:BEAT_WIDTH];
            default: o_tdata = r_data[3*BEAT_WIDTH-1:2*BEAT_WIDTH];
         endcase
      end
   end

   assign o_tvalid = r_vld;
   assign o_tlast  = r_vld && r_last && (r_idx == BEAT2);

endmodule

// File: rtl/axis_event_packetizer.sv
// Packs 96-bit events into 3-beat AXIS output; a one-event hold slot lets tlast be decided
// (count or idle timeout) before an event's first beat leaves. Input stalls while H and O are both busy.
module axis_event_packetizer
   import axis_event_pkg::*;
#(
   parameter int C_S_TDATA_WIDTH  = 96,
   parameter int C_M_TDATA_WIDTH  = 32,
   parameter int C_MAX_EVENTS     = 256,
   parameter int C_TIMEOUT_CYCLES = 1000
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [C_S_TDATA_WIDTH-1:0] s_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [C_M_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic                       timeout_flush
);

   localparam int               CNT_W    = clog2(C_MAX_EVENTS);
   localparam int               TMO_W    = clog2(C_TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_MAX_EVENTS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT_CYCLES - 1);

   logic [C_S_TDATA_WIDTH-1:0] r_h_data;
   logic                       r_h_vld;
   logic [CNT_W-1:0]           r_evt_cnt;
   logic [TMO_W-1:0]           r_tmo_cnt;
   logic                       w_o_free;
   logic                       w_cnt_hit;
   logic                       w_tmo_hit;
   logic                       w_close;
   logic                       w_h_to_o;
   logic                       w_s_hs;

   assign w_cnt_hit = (r_evt_cnt == CNT_LAST);
   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
   assign w_close   = w_cnt_hit || w_tmo_hit;
   assign w_h_to_o  = r_h_vld && w_o_free && (s_axis_tvalid || w_close);

   // Independent of tvalid: whenever tvalid is high this equals !H.valid || h_to_o.
   assign s_axis_tready = aresetn && (!r_h_vld || w_o_free);
   assign w_s_hs        = s_axis_tvalid && s_axis_tready;
   // A close that is both count and timeout is reported as a count close.
   assign timeout_flush = aresetn && w_h_to_o && w_tmo_hit && !w_cnt_hit;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_h_data  <= '0;
         r_h_vld   <= 1'b0;
         r_evt_cnt <= '0;
         r_tmo_cnt <= '0;
      end else begin
         if (w_s_hs) begin
            r_h_data <= s_axis_tdata;
            r_h_vld  <= 1'b1;
         end else if (w_h_to_o) begin
            r_h_vld  <= 1'b0;
         end

         if (w_h_to_o) r_evt_cnt <= w_close ? '0 : r_evt_cnt + 1'b1;

         // Idle counter saturates so a stalled O still sees the timeout when it frees.
         if (!r_h_vld || w_s_hs || w_h_to_o)
            r_tmo_cnt <= '0;
         else if (!s_axis_tvalid && !w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   axis_event_serializer u_ser (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .i_load   (w_h_to_o),
      .i_data   (r_h_data),
      .i_last   (w_close),
      .o_free   (w_o_free),
      .o_tvalid (m_axis_tvalid),
      .i_tready (m_axis_tready),
      .o_tdata  (m_axis_tdata),
      .o_tlast  (m_axis_tlast)
   );

endmodule

// File: tb/tb_axis_event_packetizer.sv
// Bench for axis_event_packetizer: one instance with 4-event packets, one with single-event packets.
module tb_axis_event_packetizer;

   typedef struct packed {
      logic [31:0] dat;
      logic        last;
   } beat_t;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, flush;
   logic [95:0] s_tdata;
   logic [31:0] m_tdata;
   logic        s1_tvalid, s1_tready, m1_tvalid, m1_tready, m1_tlast, flush1;
   logic [95:0] s1_tdata;
   logic [31:0] m1_tdata;

   beat_t q0[$];
   beat_t q1[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    f0       = 0;
   int    f1       = 0;

   axis_event_packetizer #(
      .C_S_TDATA_WIDTH(96), .C_M_TDATA_WIDTH(32), .C_MAX_EVENTS(4), .C_TIMEOUT_CYCLES(10)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tlast(m_tlast), .timeout_flush(flush)
   );

   axis_event_packetizer #(
      .C_S_TDATA_WIDTH(96), .C_M_TDATA_WIDTH(32), .C_MAX_EVENTS(1), .C_TIMEOUT_CYCLES(10)
   ) dut1 (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tdata(s1_tdata),
      .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tdata(m1_tdata),
      .m_axis_tlast(m1_tlast), .timeout_flush(flush1)
   );

   initial forever #5 aclk = ~aclk;

   function automatic logic [95:0] evt(input int k);
      return {32'(3*k + 3), 32'(3*k + 2), 32'(3*k + 1)};
   endfunction

   task automatic push_evt(input bit sel, input logic [95:0] d, input bit last);
      beat_t bt;
      for (int b = 0; b < 3; b++) begin
         bt.dat  = d[32*b +: 32];
         bt.last = last && (b == 2);
         if (sel) q1.push_back(bt);
         else     q0.push_back(bt);
      end
   endtask

   // Compares every presented beat (stalled or not) against the head of the expected queue.
   task automatic monitor();
      forever begin
         @(negedge aclk);
         if (aresetn === 1'b1) begin
            if (m_tvalid === 1'b1) begin
               n_checks++;
               if (q0.size() == 0)
                  $display("FAIL beat_a: unexpected beat data=%h last=%b, no beat expected", m_tdata, m_tlast);
               else if (m_tdata !== q0[0].dat || m_tlast !== q0[0].last)
                  $display("FAIL beat_a: data=%h last=%b, expected data=%h last=%b",
                           m_tdata, m_tlast, q0[0].dat, q0[0].last);
               else
                  n_pass++;
               if (m_tready === 1'b1 && q0.size() != 0) void'(q0.pop_front());
            end
            if (m1_tvalid === 1'b1) begin
               n_checks++;
               if (q1.size() == 0)
                  $display("FAIL beat_b: unexpected beat data=%h last=%b, no beat expected", m1_tdata, m1_tlast);
               else if (m1_tdata !== q1[0].dat || m1_tlast !== q1[0].last)
                  $display("FAIL beat_b: data=%h last=%b, expected data=%h last=%b",
                           m1_tdata, m1_tlast, q1[0].dat, q1[0].last);
               else
                  n_pass++;
               if (m1_tready === 1'b1 && q1.size() != 0) void'(q1.pop_front());
            end
            if (flush === 1'b1)  f0++;
            if (flush1 === 1'b1) f1++;
         end
      end
   endtask

   // Call only just after a rising edge.
   task automatic send_evt(input bit sel, input logic [95:0] d);
      int t;
      t = 0;
      if (sel) begin s1_tvalid = 1'b1; s1_tdata = d; end
      else     begin s_tvalid  = 1'b1; s_tdata  = d; end
      @(negedge aclk);
      while (((sel ? s1_tready : s_tready) !== 1'b1) && t < 200) begin
         @(negedge aclk);
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         $display("FAIL send: s_axis_tready stayed low for 200 cycles, expected 1");
      end
      @(posedge aclk);
      #1;
      s_tvalid  = 1'b0;
      s1_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || m_tvalid === 1'b1 || m1_tvalid === 1'b1) && t < 400) begin
         @(negedge aclk);
         t++;
      end
      n_checks++;
      if (t >= 400)
         $display("FAIL drain: %0d/%0d beats still outstanding after 400 cycles, expected 0", q0.size(), q1.size());
      else
         n_pass++;
   endtask

   task automatic apply_reset();
      aresetn   = 1'b0;
      s_tvalid  = 1'b0;
      s1_tvalid = 1'b0;
      s_tdata   = '0;
      s1_tdata  = '0;
      m_tready  = 1'b1;
      m1_tready = 1'b1;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      q0.delete();
      q1.delete();
   endtask

   task automatic check_flush(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: %0d timeout_flush pulses, expected %0d", name, got, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      @(negedge aclk);
      n_checks++;
      if ({s_tready, s1_tready} !== 2'b00)
         $display("FAIL rst_ready: s_tready=%b/%b, expected 0/0", s_tready, s1_tready);
      else n_pass++;
      apply_reset();
      @(negedge aclk);
      n_checks++;
      if ({m_tvalid, m_tlast, flush, s_tready} !== 4'b0001)
         $display("FAIL rst_outs: tvalid/tlast/flush/tready=%b, expected 0001", {m_tvalid, m_tlast, flush, s_tready});
      else n_pass++;
      n_checks++;
      if (m_tdata !== 32'h0 || m1_tvalid !== 1'b0)
         $display("FAIL rst_data: tdata=%h m1_tvalid=%b, expected 0 and 0", m_tdata, m1_tvalid);
      else n_pass++;
   endtask

   task automatic test_stream();
      int base;
      apply_reset();
      base = f0;
      for (int k = 0; k < 8; k++) begin
         push_evt(0, evt(k), (k == 3) || (k == 7));
         send_evt(0, evt(k));
      end
      wait_drain();
      check_flush("flush_stream", f0 - base, 0);
   endtask

   task automatic test_timeout();
      int base, n;
      apply_reset();
      base = f0;
      push_evt(0, evt(20), 1'b1);
      send_evt(0, evt(20));
      n = 0;
      do begin
         @(negedge aclk);
         n++;
      end while (m_tvalid !== 1'b1 && n < 50);
      n_checks++;
      if (n !== 11) $display("FAIL tmo_latency: first beat after %0d cycles, expected 11", n);
      else n_pass++;
      wait_drain();
      check_flush("flush_timeout", f0 - base, 1);
   endtask

   task automatic test_toggle();
      int base;
      apply_reset();
      base = f0;
      for (int k = 0; k < 8; k++) push_evt(0, evt(40 + k), (k == 3) || (k == 7));
      fork
         begin
            for (int k = 0; k < 8; k++) send_evt(0, evt(40 + k));
         end
         begin
            for (int c = 0; c < 60; c++) begin
               m_tready = ((c % 2) == 0);
               @(posedge aclk);
               #1;
            end
         end
      join
      m_tready = 1'b1;
      wait_drain();
      check_flush("flush_toggle", f0 - base, 0);
   endtask

   task automatic test_backpressure();
      int   base;
      logic exp_rdy[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      apply_reset();
      base = f0;
      m_tready = 1'b0;
      push_evt(0, evt(60), 1'b0);
      push_evt(0, evt(61), 1'b1);
      send_evt(0, evt(60));
      send_evt(0, evt(61));
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         n_checks++;
         if (s_tready !== exp_rdy[i])
            $display("FAIL bp_ready%0d: s_tready=%b, expected %b", i, s_tready, exp_rdy[i]);
         else n_pass++;
         if (i == 0) begin
            @(posedge aclk);
            #1 m_tready = 1'b1;
         end
      end
      wait_drain();
      check_flush("flush_bp", f0 - base, 1);
   endtask

   task automatic test_tmo_edge();
      int base;
      apply_reset();
      base = f0;
      push_evt(0, evt(80), 1'b1);
      push_evt(0, evt(81), 1'b1);
      send_evt(0, evt(80));
      repeat (9) @(posedge aclk);
      #1;
      send_evt(0, evt(81));
      wait_drain();
      check_flush("flush_tmo_edge", f0 - base, 2);
   endtask

   task automatic test_tmo_cnt_edge();
      int base;
      apply_reset();
      base = f0;
      for (int k = 0; k < 4; k++) push_evt(0, evt(90 + k), k == 3);
      for (int k = 0; k < 4; k++) send_evt(0, evt(90 + k));
      m_tready = 1'b0;
      repeat (20) @(posedge aclk);
      #1 m_tready = 1'b1;
      wait_drain();
      check_flush("flush_tmo_cnt", f0 - base, 0);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      push_evt(0, evt(100), 1'b0);
      send_evt(0, evt(100));
      send_evt(0, evt(101));
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      q0.delete();
      @(negedge aclk);
      n_checks++;
      if (s_tready !== 1'b0) $display("FAIL mid_rst_ready: s_tready=%b, expected 0", s_tready);
      else n_pass++;
      @(posedge aclk);
      #1 aresetn = 1'b1;
      @(negedge aclk);
      n_checks++;
      if ({m_tvalid, m_tlast} !== 2'b00)
         $display("FAIL mid_rst_out: tvalid/tlast=%b, expected 00", {m_tvalid, m_tlast});
      else n_pass++;
      @(posedge aclk);
      #1;
      for (int k = 0; k < 4; k++) begin
         push_evt(0, evt(110 + k), k == 3);
         send_evt(0, evt(110 + k));
      end
      wait_drain();
   endtask

   task automatic test_max1();
      int base;
      apply_reset();
      base = f1;
      for (int k = 0; k < 3; k++) begin
         push_evt(1, evt(120 + k), 1'b1);
         send_evt(1, evt(120 + k));
      end
      wait_drain();
      check_flush("flush_max1", f1 - base, 0);
   endtask

   initial begin
      aresetn   = 1'b0;
      s_tvalid  = 1'b0;
      s1_tvalid = 1'b0;
      s_tdata   = '0;
      s1_tdata  = '0;
      m_tready  = 1'b1;
      m1_tready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_stream();
      test_timeout();
      test_toggle();
      test_backpressure();
      test_tmo_edge();
      test_tmo_cnt_edge();
      test_reset_mid();
      test_max1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
